// File: rtl/win_pkg.sv
// Shared defaults and window element indices for the 3x3 window generator.
package win_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 8;
    localparam int DEF_IMG_H  = 8;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;
    localparam int WIN_N  = 9;

endpackage

// File: rtl/win_line_buf.sv
// Row-delay line: a DEPTH-deep shift register that advances only when en is high;
// dout is the value shifted in DEPTH enables ago.
module win_line_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // NOTE: storage arrays are left out of reset; stale contents are masked downstream,
    // and skipping the reset keeps the array mappable to plain flops/SRLs.
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/win3x3_gen.sv
// Streaming 3x3 window generator with ready/valid on both sides.
// Optional macro WIN3X3_LAST_EN adds win_last, flagging the final window of a frame.
module win3x3_gen
    import win_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [DATA_W-1:0]       pix_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [WIN_N*DATA_W-1:0] win_data
`ifdef WIN3X3_LAST_EN
    ,
    output logic                    win_last
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              win_valid_q, win_valid_d;
    logic [DATA_W-1:0] win_q [WIN_N];
    logic [DATA_W-1:0] win_d [WIN_N];
    logic [DATA_W-1:0] lb1_out, lb2_out;
    logic              pix_accept;

    // No skid buffer: a held window blocks the input until it is taken.
    assign pix_ready  = !win_valid_q || win_ready;
    assign pix_accept = pix_valid && pix_ready;

    win_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk  (clk),
        .en   (pix_accept),
        .din  (pix_data),
        .dout (lb1_out)
    );

    win_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
        .clk  (clk),
        .en   (pix_accept),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        win_d       = win_q;
        if (pix_accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[WIN_TR] = lb2_out;
            win_d[WIN_MR] = lb1_out;
            win_d[WIN_BR] = pix_data;
            // Row/column gating keeps windows from spanning a row wrap or frame edge.
            win_valid_d   = (row_q >= RW'(2)) && (col_q >= CW'(2));
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            for (int k = 0; k < WIN_N; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    assign win_valid = win_valid_q;

    for (genvar k = 0; k < WIN_N; k++) begin : g_pack
        assign win_data[k*DATA_W +: DATA_W] = win_q[k];
    end

`ifdef WIN3X3_LAST_EN
    logic win_last_q, win_last_d;

    always_comb begin
        win_last_d = win_last_q;
        if (pix_accept) begin
            win_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end else if (win_ready) begin
            win_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_last_q <= 1'b0;
        end else begin
            win_last_q <= win_last_d;
        end
    end

    assign win_last = win_last_q;
`endif

endmodule
